fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
- Read-side controller for the 32-entry 2-port RAM FIFO.
- Consumes the write-side pointer from the write counter and generates read addresses for the RAM's synchronous read port.
- Captures RAM data into an output register and presents it over a valid/ready handshake.
- Returns its own read pointer to the write side for full detection.

Parameters:
- ADDR_W, 5, RAM address width; FIFO depth = 2**ADDR_W (32).
- DATA_W, 8, RAM word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- wr_ptr  in  ADDR_W+1  write pointer from the write side; MSB is the wrap bit.
- rd_addr  out  ADDR_W  RAM read address.
- ram_q  in  DATA_W  RAM read data; valid the cycle after rd_addr is sampled.
- rd_ptr  out  ADDR_W+1  read pointer including wrap bit; goes to the write side.
- out_data  out  DATA_W  output word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts the word.
- empty  out  1  no unread words in RAM.
- count  out  ADDR_W+1  unread words in RAM; excludes the word held in out_data.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rd_ptr=0; out_data=0; out_valid=0. Combinational outputs follow from these values: rd_addr=0, and empty/count derive from wr_ptr.
- Reset wins over every other event, in any state, and may assert mid-transfer. A held word is discarded and nothing resumes.
- Combinational outputs:
  - rd_addr = rd_ptr[ADDR_W-1:0]
  - empty = (wr_ptr == rd_ptr), compared on all ADDR_W+1 bits
  - count = (wr_ptr - rd_ptr) mod 2**(ADDR_W+1)
- Full RAM appears as wr_ptr = rd_ptr ^ (1<<ADDR_W): count=32, empty=0. This block does not detect full.
- Pointer arithmetic wraps naturally: 63 -> 0 for ADDR_W=5. There is no saturation.
- A "read issue" means rd_ptr <= rd_ptr + 1 at the clock edge. The RAM samples the old rd_addr on that same edge.
- FSM states:
  - IDLE: out_valid=0.
    - If !empty: read issue, next state FETCH.
    - Else: stay in IDLE.
  - FETCH: ram_q now holds the issued word.
    - out_data <= ram_q; out_valid <= 1; next state HOLD.
    - No read is issued in FETCH.
  - HOLD: out_valid=1; out_data stable.
    - If out_ready && !empty: read issue, out_valid <= 0, next state FETCH.
    - If out_ready && empty: out_valid <= 0, next state IDLE.
    - If !out_ready: stay in HOLD. out_data and rd_ptr are unchanged.
- Latency: empty falls before edge N -> read issued at edge N -> out_valid=1 after edge N+1.
- Throughput: at most one word per 2 cycles.
- Simultaneous events: a wr_ptr change on the same edge as a read issue is fine. empty/count use the current values; the new write is seen next cycle.
- Illegal input: count > 2**ADDR_W is caller error. No check is made; behaviour is unspecified but must not hang the FSM.

Optional Feature:
- Macro FIFO_READ_CTRL_RDCNT_EN.
- Defined: adds output rd_total [15:0].
  - Reset value 0.
  - Increments on each out_valid && out_ready cycle.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset values: hold reset=0 with wr_ptr=0 -> rd_ptr=0, rd_addr=0, out_valid=0, out_data=0, empty=1, count=0. Release reset -> FSM stays IDLE.
- Single word: RAM[0]=8'hA5, wr_ptr 0->1, out_ready=1.
  - Read issued at the next edge; out_valid=1 with out_data=8'hA5 two edges after the change.
  - Handshake -> out_valid=0, empty=1, rd_ptr=1.
- Full drain: preload 32 words 0..31, wr_ptr=6'd32.
  - Check count=32, empty=0 before the first read.
  - out_ready=1 -> words 0..31 delivered in order, one per 2 cycles.
  - End state: rd_ptr=32, empty=1, count=0.
- Backpressure: in HOLD with out_data=8'h3C, hold out_ready=0 for 10 cycles while wr_ptr advances by 3.
  - out_data stays 8'h3C, out_valid stays 1, rd_ptr is unchanged, count rises by 3.
  - Raise out_ready -> next word follows.
- Pointer wrap: start rd_ptr=wr_ptr=62, write 4 words.
  - Reads at addresses 30, 31, 0, 1.
  - rd_ptr sequence 63 -> 0 -> 1 -> 2; empty=1 at rd_ptr=2.
- Reset mid-operation: pull reset=0 asynchronously, between edges, during HOLD.
  - out_valid and rd_ptr drop to 0 immediately.
  - After release with wr_ptr=3, reads restart from address 0.
  - With FIFO_READ_CTRL_RDCNT_EN defined, rd_total also returns to 0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side controller for a 2**ADDR_W-entry two-port RAM FIFO. It compares
// the write pointer against its own read pointer, issues reads to the RAM's
// synchronous read port, captures the returned word into an output register
// and offers it downstream over a valid/ready handshake. The read pointer is
// returned to the write side so that side can detect full.
//
// Parameters:
//   ADDR_W    RAM address width; FIFO depth is 2**ADDR_W
//   DATA_W    RAM word width
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   wr_ptr    write pointer from the write side, MSB is the wrap bit
//   rd_addr   RAM read address (low bits of rd_ptr)
//   ram_q     RAM read data, valid the cycle after rd_addr is sampled
//   rd_ptr    read pointer including wrap bit, returned to the write side
//   out_data  output word
//   out_valid out_data holds an unconsumed word
//   out_ready downstream accepts the word
//   empty     no unread words left in the RAM
//   count     unread words in the RAM (the word in out_data is not counted)
//   rd_total  (only with FIFO_READ_CTRL_RDCNT_EN) saturating count of
//             accepted words
//
// Optional feature macro: FIFO_READ_CTRL_RDCNT_EN
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              empty,
    output logic [ADDR_W:0]   count
`ifdef FIFO_READ_CTRL_RDCNT_EN
    ,
    output logic [15:0]       rd_total
`endif
);

    // State encoding; the unused code falls back to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDR_W:0]   PTR_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W:0]   rd_ptr_r;
    logic [ADDR_W:0]   rd_ptr_nxt_s;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] out_data_nxt_s;
    logic              out_valid_r;
    logic              out_valid_nxt_s;
    logic              empty_s;

    // Empty compares the wrap bit too, so a full RAM (pointers differing
    // only in the MSB) reads as not empty with count = 2**ADDR_W.
    assign empty_s   = (wr_ptr == rd_ptr_r);
    assign empty     = empty_s;
    assign count     = wr_ptr - rd_ptr_r;
    assign rd_addr   = rd_ptr_r[ADDR_W-1:0];
    assign rd_ptr    = rd_ptr_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    // Next-state logic: one read in flight at a time, so a word takes an
    // issue cycle (IDLE/HOLD) and a capture cycle (FETCH).
    always_comb begin
        state_nxt_s     = state_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                out_valid_nxt_s = 1'b0;
                if (!empty_s) begin
                    // RAM samples the old rd_addr on this same edge.
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                    state_nxt_s  = ST_FETCH;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                out_data_nxt_s  = ram_q;
                out_valid_nxt_s = 1'b1;
                state_nxt_s     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    if (!empty_s) begin
                        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                        state_nxt_s  = ST_FETCH;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rd_ptr_r    <= PTR_ZERO;
            out_data_r  <= DATA_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

`ifdef FIFO_READ_CTRL_RDCNT_EN
    logic [15:0] rd_total_r;

    assign rd_total = rd_total_r;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_total_r <= 16'd0;
        end else if (out_valid_r && out_ready && (rd_total_r != 16'hFFFF)) begin
            rd_total_r <= rd_total_r + 16'd1;
        end else begin
            rd_total_r <= rd_total_r;
        end
    end
`endif

endmodule
